reg_bank_master: RTL
====================

Name: reg_bank_master

Overview:
Initiator for the 16x16 register bank. It accepts burst commands (read or write, start address, length) over a valid/ready handshake. It sequences the bank's write_en/read_en/addr/data_in strobes one beat at a time and returns read data on a response channel with backpressure. It sits between the host/command logic and the bank top, and replaces direct host driving of the bank pins.

Parameters:
ADDR_W, 4, bank address width (16 registers)
DATA_W, 16, register data width
RD_LAT, 1, cycles from read_en/addr driven to bank data_out valid (0 = combinational read)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  master can accept a command
cmd_op  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  start register
cmd_len  in  ADDR_W  beats minus one (0..15 → 1..16 beats)
wr_valid  in  1  write beat data present
wr_ready  out  1  write beat accepted
wr_data  in  DATA_W  write beat data
rsp_valid  out  1  read beat available
rsp_ready  in  1  consumer takes read beat
rsp_data  out  DATA_W  read beat data
rsp_last  out  1  final beat of read burst
busy  out  1  burst in progress (state != IDLE)
write_en  out  1  to bank
read_en  out  1  to bank
addr  out  ADDR_W  to bank
data_in  out  DATA_W  to bank
data_out  in  DATA_W  from bank

Behaviour:
- Reset (async, rst=1): state IDLE; write_en, read_en, addr, data_in, rsp_valid, rsp_data, rsp_last = 0; internal counters = 0. All bank-side outputs and rsp_* are registered.
- Asserting rst mid-burst aborts immediately. No partial write completes after reset; no response is emitted.
- Handshakes: a transfer occurs on a cycle where valid && ready. A producer must not drop valid before the transfer. rsp_data and rsp_last hold stable while rsp_valid && !rsp_ready.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE: cmd_ready=1.
  - On cmd transfer: latch cur_addr=cmd_addr and beats_left=cmd_len.
  - Next state is WR if cmd_op=1, else RD_ISSUE.
  - cmd_ready=0 in every other state; commands presented while busy are not accepted.
- WR: wr_ready=1 (combinational from state).
  - On wr transfer in cycle T, during T+1: write_en=1, addr=cur_addr, data_in=wr_data.
  - write_en lasts exactly one cycle per beat; back-to-back beats give a continuous write_en.
  - After each beat, cur_addr increments modulo 16 (15 → 0 wrap).
  - If beats_left==0, go to IDLE; otherwise decrement beats_left.
- RD_ISSUE (cycle T): during T+1, read_en=1 for one cycle and addr=cur_addr. Load lat_cnt=RD_LAT. Go to RD_WAIT.
- addr holds its value until the next beat is issued. data_in holds the last written value.
- RD_WAIT: the bank sample point is the cycle in which read_en is high plus RD_LAT cycles.
  - At that edge, capture data_out into rsp_data, set rsp_valid=1 and rsp_last=(beats_left==0). Go to RD_RESP.
  - RD_LAT=0: the capture occurs in the read_en cycle itself.
- RD_RESP: hold the response until rsp_ready.
  - On transfer: rsp_valid=0.
  - If rsp_last, go to IDLE. Otherwise cur_addr+1 mod 16, beats_left-1, go to RD_ISSUE.
- Only one read is outstanding at a time. Beat period is ≥ 3+RD_LAT cycles.
- write_en and read_en are never high in the same cycle.
- busy = (state != IDLE). It deasserts the cycle after the final write beat is accepted or the final read response transfers.

Decomposition:
- Shared package reg_bank_pkg:
  - ADDR_W and DATA_W constants
  - OP_READ=0 / OP_WRITE=1 localparams
  - FSM state encoding (3-bit; IDLE=0)
  - NUM_REGS=16
- No sub-module is warranted. The latency counter and burst counters stay inline in reg_bank_master.

Test Plan:
- Reset: assert rst mid-read (state RD_WAIT) → the same cycle, read_en=0 and rsp_valid=0. After release: cmd_ready=1, busy=0, addr=0.
- Single write: cmd op=1, addr=5, len=0; wr_data=16'hBEEF → exactly one cycle with write_en=1, addr=5, data_in=BEEF; then busy=0. A follow-up read of addr 5 returns BEEF with rsp_last=1.
- Wrap burst: write addr=14, len=3, data A0..A3 → writes to 14, 15, 0, 1 in order. Read back addr=14, len=3 → rsp_data A0, A1, A2, A3; rsp_last only on A3.
- Backpressure: read burst len=1 with rsp_ready held low for 5 cycles → rsp_valid and rsp_data stable. No second read_en is issued until the first beat transfers.
- Write stall: wr_valid toggles 1,0,0,1 → write_en only follows accepted beats, and addresses increment only on transfers.
- Command while busy / RD_LAT=0 build: cmd_valid held during a burst → not accepted until IDLE. With RD_LAT=0, data is captured in the read_en cycle and values match the bank model.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants for the 16x16 register bank and its burst master.
// Holds bank geometry, command opcodes and the master FSM state encoding.
// No logic; imported by the master.
package reg_bank_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Three-bit state encoding; IDLE must stay zero so reset lands there.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR       = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RD_RESP  = 3'd4;

endpackage

// File: rtl/reg_bank_master.sv
// Burst initiator for the register bank: turns read/write burst commands
// into single-beat write_en/read_en strobes and returns read data.
// Ports: clk/rst; cmd_* burst command (valid/ready); wr_* write beats
// (valid/ready); rsp_* read beats (valid/ready, last); busy; bank-side
// write_en/read_en/addr/data_in (registered) and data_out from the bank.
module reg_bank_master #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              write_en,
    output logic              read_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);
    import reg_bank_pkg::*;

    // Counter wide enough to hold RD_LAT; at least one bit so RD_LAT=0 builds.
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT);

    logic [2:0]        state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] beats_left;
    logic [LAT_W-1:0]  lat_cnt;

    assign cmd_ready = (state == S_IDLE);
    assign wr_ready  = (state == S_WR);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
            lat_cnt    <= '0;
            write_en   <= 1'b0;
            read_en    <= 1'b0;
            addr       <= '0;
            data_in    <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_last   <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses; only the issuing states raise them.
            write_en <= 1'b0;
            read_en  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr   <= cmd_addr;
                        beats_left <= cmd_len;
                        state      <= (cmd_op == OP_WRITE) ? S_WR : S_RD_ISSUE;
                    end
                end
                S_WR: begin
                    if (wr_valid) begin
                        write_en <= 1'b1;
                        addr     <= cur_addr;
                        data_in  <= wr_data;
                        cur_addr <= cur_addr + 1'b1;  // wraps at the top of the bank
                        if (beats_left == '0) begin
                            state <= S_IDLE;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    read_en <= 1'b1;
                    addr    <= cur_addr;
                    lat_cnt <= LAT_INIT;
                    state   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // First RD_WAIT cycle is the read_en cycle; capture RD_LAT cycles later.
                    if (lat_cnt == '0) begin
                        rsp_data  <= data_out;
                        rsp_valid <= 1'b1;
                        rsp_last  <= (beats_left == '0);
                        state     <= S_RD_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_RD_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            state <= S_IDLE;
                        end else begin
                            cur_addr   <= cur_addr + 1'b1;
                            beats_left <= beats_left - 1'b1;
                            state      <= S_RD_ISSUE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
